// File: rtl/w4823_fir_outfmt_if.sv
// w4823_fir_outfmt_if: FP29i input stream and FP16 output stream of the output formatter
interface w4823_fir_outfmt_if;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] in_fp29i;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] dout;
    logic        out_ovf;
    logic        out_unf;
    modport slave (
        input  in_valid, in_fp29i, out_ready,
        output in_ready, out_valid, dout, out_ovf, out_unf
    );
    modport master (
        output in_valid, in_fp29i, out_ready,
        input  in_ready, out_valid, dout, out_ovf, out_unf
    );
endinterface

// File: rtl/w4823_fir_outfmt.sv
// w4823_fir_outfmt: normalizes an FP29i accumulator result one bit per cycle,
// rounds to nearest-even and packs it as FP16 with saturation and flush-to-zero.
module w4823_fir_outfmt #(
    parameter int EXP_BIAS_IN = 63
) (
    input logic clk2,
    input logic rst_n,
    w4823_fir_outfmt_if.slave bus
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;
    state_t             state;
    logic               s;
    logic               zero;
    logic               sticky;
    logic [21:0]        m;
    logic signed [8:0]  ex;
    logic               st;
    logic               up;
    logic [10:0]        frac_r;
    logic signed [10:0] e16;
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == OUT;
    // frac_r[10] is the carry out of the fraction; it bumps the exponent
    always_comb begin
        st     = |m[8:0] | sticky;
        up     = m[9] & (st | m[10]);
        frac_r = {1'b0, m[19:10]} + {10'd0, up};
        e16    = {{2{ex[8]}}, ex} + {10'd0, frac_r[10]} - 11'(EXP_BIAS_IN) + 11'sd15;
    end
    always_ff @(posedge clk2) begin
        if (!rst_n) begin
            state       <= IDLE;
            s           <= 1'b0;
            zero        <= 1'b0;
            sticky      <= 1'b0;
            m           <= '0;
            ex          <= '0;
            bus.dout    <= 16'h0000;
            bus.out_ovf <= 1'b0;
            bus.out_unf <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    s      <= bus.in_fp29i[29];
                    ex     <= {2'b00, bus.in_fp29i[28:22]};
                    m      <= bus.in_fp29i[21:0];
                    sticky <= 1'b0;
                    zero   <= 1'b0;
                    state  <= NORM;
                end
                NORM: if (m == '0) begin
                    zero  <= 1'b1;
                    state <= ROUND;
                end else if (m[21]) begin
                    m      <= m >> 1;
                    sticky <= sticky | m[0];
                    ex     <= ex + 9'sd1;
                end else if (m[20]) begin
                    state <= ROUND;
                end else begin
                    m  <= m << 1;
                    ex <= ex - 9'sd1;
                end
                ROUND: begin
                    bus.dout    <= zero ? {s, 15'h0} :
                                   e16 >= 31 ? {s, 5'h1F, 10'h0} :
                                   e16 <= 0 ? {s, 15'h0} : {s, e16[4:0], frac_r[9:0]};
                    bus.out_ovf <= !zero && e16 >= 31;
                    bus.out_unf <= !zero && e16 < 31 && e16 <= 0;
                    state       <= OUT;
                end
                OUT: if (bus.out_ready) state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/w4823_fir_outfmt.md
W4823_FIR_OUTFMT -- requirements
Module: w4823_fir_outfmt

Interface
REQ-001 The block SHALL have one parameter: EXP_BIAS_IN, default 63, the exponent bias of the FP29i input.
REQ-002 clk2  in  1  fast clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 in_valid  in  1  an FP29i accumulator result is offered.
REQ-005 in_ready  out  1  the block can accept an input.
REQ-006 in_fp29i  in  30  bit [29] sign, bits [28:22] exponent, bits [21:0] unnormalized mantissa.
REQ-007 out_valid  out  1  dout holds a completed FP16 result.
REQ-008 out_ready  in  1  the consumer accepts dout.
REQ-009 dout  out  16  FP16 result: sign, 5-bit exponent with bias 15, 10-bit fraction.
REQ-010 out_ovf  out  1  the current result saturated to infinity.
REQ-011 out_unf  out  1  the current result was flushed to zero.

Function
REQ-012 The input value SHALL be (-1)^s × m × 2^(e − EXP_BIAS_IN − 20); the normalized form has m[21]=0 and m[20]=1.
REQ-013 The FSM SHALL have four states, IDLE, NORM, ROUND and OUT, and in_ready SHALL be 1 only in IDLE.
REQ-014 IDLE: when in_valid=1, the block SHALL latch s, e and m, clear sticky, and go to NORM.
REQ-015 Internal exponent: 9-bit signed, loaded with e zero-extended, never wrapping.
REQ-016 NORM, one step per cycle, priority order:
- m==0: flag zero, go to ROUND.
- m[21]=1: shift m right 1, OR the dropped bit into sticky, exponent +1, stay in NORM.
- m[20]=1: go to ROUND.
- otherwise: shift m left 1, exponent −1, stay in NORM.
REQ-017 The NORM step count SHALL be bounded: at most 1 right shift and at most 20 left shifts.
REQ-018 ROUND inputs:
- fraction = m[19:10];
- guard = m[9];
- sticky' = |m[8:0] OR sticky.
REQ-019 ROUND rule: round to nearest, ties to even; round up when guard=1 and (sticky'=1 or fraction[0]=1).
REQ-020 Fraction carry-out: if rounding carries out of the fraction, the fraction SHALL become 0 and the exponent SHALL increment.
REQ-021 E16 = exponent − EXP_BIAS_IN + 15, computed after rounding.
REQ-022 Packing, in ROUND, in priority order:
- zero flag set: dout = {s, 15'h0}, both flags 0.
- E16 ≥ 31: dout = {s, 5'h1F, 10'h0}, out_ovf = 1.
- E16 ≤ 0: dout = {s, 15'h0}, out_unf = 1 (subnormals are not produced).
- otherwise: dout = {s, E16[4:0], fraction}.
REQ-023 ROUND SHALL go to OUT, and out_valid SHALL be 1 in OUT.
REQ-024 In OUT, dout, out_ovf and out_unf SHALL stay stable while out_ready=0.
REQ-025 When out_valid=1 and out_ready=1, the block SHALL return to IDLE in the next cycle.
REQ-026 A new input SHALL be accepted no earlier than the cycle after the output handshake; the block does not accept input in the same cycle as the handshake.
REQ-027 Latency, with the input accepted at cycle N:
- normalized input: out_valid first at N+3;
- each left or right shift adds 1 cycle;
- zero input: out_valid at N+3;
- maximum: N+23.
REQ-028 in_valid while the block is not in IDLE SHALL be ignored; the upstream holds the input until in_ready=1.

Reset
REQ-029 With rst_n=0 at a clk2 edge, the block SHALL enter IDLE and set out_valid=0, in_ready=1, dout=16'h0000, out_ovf=0 and out_unf=0.
REQ-030 Reset SHALL override any state, including mid-NORM and OUT, and any partially processed result SHALL be discarded without a handshake.

Verification
REQ-031 Normalized input:
- stimulus: s=0, e=63, m=22'h100000 at cycle N;
- response: dout=16'h3C00, flags 0, out_valid at N+3.
REQ-032 Shift latency:
- stimulus: e=64, m=22'h080000;
- response: 16'h3C00 at N+4.
- stimulus: e=63, m=22'h200000;
- response: 16'h4000 at N+4.
REQ-033 Rounding:
- m=22'h100200, e=63 → 16'h3C00 (tie, fraction even, no round up).
- m=22'h100600, e=63 → 16'h3C02 (tie, fraction odd, round up).
- m=22'h1FFE00, e=63 → 16'h4000 (carry-out increments the exponent).
REQ-034 Range limits:
- e=100, m=22'h100000 → 16'h7C00, out_ovf=1.
- e=40, m=22'h100000 → 16'h0000, out_unf=1.
- s=1, m=0 → 16'h8000, both flags 0.
REQ-035 Backpressure and reset:
- out_ready held 0 for 5 cycles → dout stable and in_ready=0 throughout;
- out_ready=1 → in_ready=1 the next cycle;
- rst_n=0 during NORM → IDLE and all outputs at reset values at the next edge.
REQ-036 Maximum left shift: e=83, m=22'h000001 → exactly 20 left shifts, dout=16'h3C00 at N+23.
